multicycle_control_fsm: RTL and testbench

//  Next-generation RV32I control unit: a multicycle Moore FSM, replacing the single-cycle opcode decoder.

---
 rtl/multicycle_control_fsm_pkg.sv | 56 +++++
 rtl/multicycle_control_fsm_if.sv | 38 +++
 rtl/multicycle_control_fsm_alu_ctrl_dec.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Purpose : shared encodings for the RV32I multicycle control unit (states, opcodes, mux selects, ALU ops).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package rv32i_ctrl_pkg;

  // Sixteen states fill the 4-bit debug port exactly. R/I execute share S_EXEC and
  // LUI/AUIPC share S_UPPER; op[5] tells each pair apart.
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXEC,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LINK, S_UPPER, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation class handed to the funct decoder.
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} alu_op_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Purpose : bundle between the control FSM (master) and the multicycle datapath/memory (slave).
// Latency : n/a (wires only).
// Backpressure: mem_ready from the slave stalls the master's memory states.
// Ports   : IR fields, ALU flags, mem_ready toward the FSM; enables, mux selects, alu_ctrl, debug toward the datapath.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct3, funct7_5, zero, lt, ltu, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal, state_o
  );

  modport slave (
    output op, funct3, funct7_5, zero, lt, ltu, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_ctrl_dec.sv
// Purpose : map ALU op class plus funct3/funct7_5/op[5] onto an alu_ctrl code.
// Latency : combinational.
// Backpressure: none.
// Ports   : alu_op, funct3, funct7_5, op5 in; alu_ctrl out.
module alu_ctrl_dec
  import rv32i_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // IR[30] is part of the immediate for addi, so only R-type may subtract.
          3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Purpose : RV32I multicycle Moore control FSM (fetch/decode/execute/memory/writeback, illegal-op trap).
// Latency : 3-6 states per instruction plus memory wait cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready when MEM_HANDSHAKE=1.
// Ports   : clk, rst_n (async active-low), ctrl (master side of multicycle_control_fsm_if).
module multicycle_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master ctrl
);

  state_t     state, state_nxt;
  alu_op_t    alu_op;
  logic       mem_done, taken, dec_bad;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;

  assign mem_done = MEM_HANDSHAKE ? ctrl.mem_ready : 1'b1;

  always_comb begin
    case (ctrl.funct3)
      3'b000:  taken = ctrl.zero;
      3'b001:  taken = !ctrl.zero;
      3'b100:  taken = ctrl.lt;
      3'b101:  taken = !ctrl.lt;
      3'b110:  taken = ctrl.ltu;
      3'b111:  taken = !ctrl.ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dec_bad    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = AOP_ADD;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the control-transfer target into ALUOut; JAL needs the J immediate.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (ctrl.op == OP_JAL) ? IMM_J : IMM_B;
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R, OP_I:        state_nxt = S_EXEC;
          OP_BRANCH: begin
            if (ctrl.funct3[2:1] == 2'b01) dec_bad   = 1'b1;
            else                           state_nxt = S_BRANCH;
          end
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
          default:           dec_bad   = 1'b1;
        endcase
        if (dec_bad) begin
          if (TRAP_ON_ILLEGAL) state_nxt = S_TRAP;
          else                 state_nxt = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = ctrl.op[5] ? IMM_S : IMM_I;
        state_nxt = ctrl.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_done) state_nxt = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_done) state_nxt = S_FETCH;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = ctrl.op[5] ? SRCB_RS2 : SRCB_IMM;
        alu_op    = AOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        imm_src   = IMM_B;
        alu_op    = AOP_SUB;
        pc_write  = taken;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target from ALUOut while the ALU forms the link value.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_JALR, S_JALR_PC: begin
        // rs1+imm stays on the ALU so JALR_PC can write it to PC straight from the ALU.
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (state == S_JALR_PC) begin
          result_src = RES_ALU;
          pc_write   = 1'b1;
          state_nxt  = S_LINK;
        end else begin
          state_nxt  = S_JALR_PC;
        end
      end
      S_LINK: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        state_nxt = S_ALUWB;
      end
      S_UPPER: begin
        alu_src_a = ctrl.op[5] ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      default: illegal = 1'b1;
    endcase
  end

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op   (alu_op),
    .funct3   (ctrl.funct3),
    .funct7_5 (ctrl.funct7_5),
    .op5      (ctrl.op[5]),
    .alu_ctrl (alu_ctrl)
  );

  assign ctrl.mem_req    = mem_req;
  assign ctrl.mem_write  = mem_write;
  assign ctrl.adr_src    = adr_src;
  assign ctrl.ir_write   = ir_write;
  assign ctrl.pc_write   = pc_write;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;
  assign ctrl.result_src = result_src;
  assign ctrl.imm_src    = imm_src;
  assign ctrl.alu_ctrl   = alu_ctrl;
  assign ctrl.illegal    = illegal;
  assign ctrl.state_o    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Purpose : self-checking bench for multicycle_control_fsm: expected per-cycle phase lists built from instruction class.
// Latency : n/a.
// Backpressure: mem_ready stalls driven from the phase list.
module tb_multicycle_control_fsm;
  import rv32i_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if ifa ();
  multicycle_control_fsm_if ifb ();

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl(ifa.master));
  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl(ifb.master));

  // Enable bundle order: {mem_req, mem_write, ir_write, pc_write, reg_write, illegal}
  localparam logic [5:0] E_MREQ = 6'b100000;
  localparam logic [5:0] E_MWR  = 6'b010000;
  localparam logic [5:0] E_IRW  = 6'b001000;
  localparam logic [5:0] E_PCW  = 6'b000100;
  localparam logic [5:0] E_RW   = 6'b000010;
  localparam logic [5:0] E_ILL  = 6'b000001;

  typedef struct packed {
    state_t     st;
    logic [5:0] en;
    logic       cd;   // check {alu_src_a, alu_src_b, alu_ctrl}
    logic [7:0] dp;
    logic       cr;   // check result_src
    logic [1:0] res;
    logic       rdy;  // mem_ready to drive during this cycle
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic sel   = 1'b0;  // 0 observes dut_a, 1 observes dut_b
  bit   hs    = 1'b1;
  bit   trp   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_state();
    return 32'(sel ? ifb.state_o : ifa.state_o);
  endfunction
  function automatic logic [31:0] obs_en();
    return sel ? 32'({ifb.mem_req, ifb.mem_write, ifb.ir_write, ifb.pc_write, ifb.reg_write, ifb.illegal})
               : 32'({ifa.mem_req, ifa.mem_write, ifa.ir_write, ifa.pc_write, ifa.reg_write, ifa.illegal});
  endfunction
  function automatic logic [31:0] obs_dp();
    return sel ? 32'({ifb.alu_src_a, ifb.alu_src_b, ifb.alu_ctrl}) : 32'({ifa.alu_src_a, ifa.alu_src_b, ifa.alu_ctrl});
  endfunction
  function automatic logic [31:0] obs_res();
    return 32'(sel ? ifb.result_src : ifa.result_src);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(state_t st, logic [5:0] en, logic cd, logic [7:0] dp,
                              logic cr, logic [1:0] res, logic rdy);
    exp_t e;
    e.st = st; e.en = en; e.cd = cd; e.dp = dp; e.cr = cr; e.res = res; e.rdy = rdy;
    q.push_back(e);
  endfunction

  function automatic logic [3:0] exp_alu(logic [2:0] f3, logic f7, bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic z, logic l, logic lu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      default: return !lu;
    endcase
  endfunction

  // Builds the expected cycle list for one instruction; returns 1 if it ends in a trap.
  function automatic bit build(logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic l, logic lu,
                               int sf, int sm);
    bit     legal = 1'b1;
    state_t mst;
    logic [5:0] men;
    q.delete();
    if (hs) for (int i = 0; i < sf; i++) add(S_FETCH, E_MREQ, 1, {SRCA_PC, SRCB_FOUR, ALU_ADD}, 1, RES_ALU, 1'b0);
    add(S_FETCH, E_MREQ | E_IRW | E_PCW, 1, {SRCA_PC, SRCB_FOUR, ALU_ADD}, 1, RES_ALU, hs ? 1'b1 : rnd1());
    add(S_DECODE, 6'd0, 1, {SRCA_OLDPC, SRCB_IMM, ALU_ADD}, 0, 2'd0, rnd1());
    case (op)
      OP_LOAD, OP_STORE: begin
        add(S_MEMADR, 6'd0, 1, {SRCA_RS1, SRCB_IMM, ALU_ADD}, 0, 2'd0, rnd1());
        mst = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        men = (op == OP_LOAD) ? E_MREQ : (E_MREQ | E_MWR);
        if (hs) for (int i = 0; i < sm; i++) add(mst, men, 0, 8'd0, 0, 2'd0, 1'b0);
        add(mst, men, 0, 8'd0, 0, 2'd0, hs ? 1'b1 : rnd1());
        if (op == OP_LOAD) add(S_MEMWB, E_RW, 0, 8'd0, 1, RES_MEM, rnd1());
      end
      OP_R, OP_I: begin
        add(S_EXEC, 6'd0, 1, {SRCA_RS1, (op == OP_R) ? SRCB_RS2 : SRCB_IMM, exp_alu(f3, f7, op == OP_R)},
            0, 2'd0, rnd1());
        add(S_ALUWB, E_RW, 0, 8'd0, 1, RES_ALUOUT, rnd1());
      end
      OP_BRANCH: begin
        if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
        else add(S_BRANCH, br_taken(f3, z, l, lu) ? E_PCW : 6'd0, 1, {SRCA_RS1, SRCB_RS2, ALU_SUB},
                 1, RES_ALUOUT, rnd1());
      end
      OP_JAL: begin
        add(S_JAL, E_PCW, 1, {SRCA_OLDPC, SRCB_FOUR, ALU_ADD}, 1, RES_ALUOUT, rnd1());
        add(S_ALUWB, E_RW, 0, 8'd0, 1, RES_ALUOUT, rnd1());
      end
      OP_JALR: begin
        add(S_JALR, 6'd0, 1, {SRCA_RS1, SRCB_IMM, ALU_ADD}, 0, 2'd0, rnd1());
        add(S_JALR_PC, E_PCW, 1, {SRCA_RS1, SRCB_IMM, ALU_ADD}, 1, RES_ALU, rnd1());
        add(S_LINK, 6'd0, 1, {SRCA_OLDPC, SRCB_FOUR, ALU_ADD}, 0, 2'd0, rnd1());
        add(S_ALUWB, E_RW, 0, 8'd0, 1, RES_ALUOUT, rnd1());
      end
      OP_LUI, OP_AUIPC: begin
        add(S_UPPER, 6'd0, 1, {(op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC, SRCB_IMM, ALU_ADD}, 0, 2'd0, rnd1());
        add(S_ALUWB, E_RW, 0, 8'd0, 1, RES_ALUOUT, rnd1());
      end
      default: legal = 1'b0;
    endcase
    if (!legal && trp) begin
      for (int i = 0; i < 10; i++) add(S_TRAP, E_ILL, 0, 8'd0, 0, 2'd0, rnd1());
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_rdy(input logic r);
    ifa.mem_ready = r;
    ifb.mem_ready = r;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic l, input logic lu);
    ifa.op = op; ifa.funct3 = f3; ifa.funct7_5 = f7; ifa.zero = z; ifa.lt = l; ifa.ltu = lu;
    ifb.op = op; ifb.funct3 = f3; ifb.funct7_5 = f7; ifb.zero = z; ifb.lt = l; ifb.ltu = lu;
  endtask

  // Entered 1 ns after a rising edge; each entry drives mem_ready then samples mid-cycle.
  task automatic run(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      set_rdy(q[i].rdy);
      #3;
      chk("state", obs_state(), 32'(q[i].st));
      chk("enables", obs_en(), 32'(q[i].en));
      if (q[i].cd) chk("datapath_sel", obs_dp(), 32'(q[i].dp));
      if (q[i].cr) chk("result_src", obs_res(), 32'(q[i].res));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_state", obs_state(), 32'(S_IDLE));
    chk("reset_enables", obs_en(), 32'd0);
    @(posedge clk); #1;
    chk("reset_hold", obs_state(), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_fetch", obs_state(), 32'(S_FETCH));
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input logic lu, input int sf, input int sm);
    bit tr;
    set_ir(op, f3, f7, z, l, lu);
    tr = build(op, f3, f7, z, l, lu, sf, sm);
    run(q.size());
    if (tr) do_reset();
  endtask

  function automatic logic [6:0] pick_op(int k);
    case (k)
      0: return OP_LOAD;   1: return OP_STORE; 2: return OP_R;    3: return OP_I;
      4: return OP_BRANCH; 5: return OP_JAL;   6: return OP_JALR; 7: return OP_LUI;
      8: return OP_AUIPC;  9: return 7'h00;    default: return 7'h0f;
    endcase
  endfunction

  task automatic rand_issue();
    issue(pick_op($urandom_range(0, 10)), 3'($urandom_range(0, 7)), rnd1(), rnd1(), rnd1(), rnd1(),
          $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    set_ir(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_rdy(1'b0);
    #12;
    chk("init_state", obs_state(), 32'(S_IDLE));
    chk("init_enables", obs_en(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_R,      3'd0, 1'b0, 0, 0, 0, 0, 0);   // add x1,x2,x3
    issue(OP_LOAD,   3'd2, 1'b0, 0, 0, 0, 0, 3);   // lw, 3 wait cycles
    issue(OP_BRANCH, 3'd1, 1'b0, 1, 0, 0, 0, 0);   // bne, equal
    issue(OP_BRANCH, 3'd1, 1'b0, 0, 0, 0, 0, 0);   // bne, not equal
    issue(OP_BRANCH, 3'd6, 1'b0, 0, 0, 1, 0, 0);   // bltu, taken
    issue(OP_JALR,   3'd0, 1'b0, 0, 0, 0, 0, 0);
    issue(OP_STORE,  3'd2, 1'b0, 0, 0, 0, 1, 2);
    issue(OP_JAL,    3'd0, 1'b0, 0, 0, 0, 0, 0);
    issue(OP_LUI,    3'd3, 1'b1, 0, 0, 0, 0, 0);
    issue(OP_AUIPC,  3'd5, 1'b0, 0, 0, 0, 2, 0);
    issue(OP_I,      3'd0, 1'b1, 0, 0, 0, 0, 0);   // addi with IR[30]=1 stays ADD
    issue(OP_R,      3'd0, 1'b1, 0, 0, 0, 0, 0);   // sub
    issue(OP_I,      3'd5, 1'b1, 0, 0, 0, 0, 0);   // srai

    // Abort a load while MEMREAD is waiting on memory.
    set_ir(OP_LOAD, 3'd2, 1'b0, 0, 0, 0);
    void'(build(OP_LOAD, 3'd2, 1'b0, 0, 0, 0, 0, 5));
    run(4);
    chk("pre_reset_memread", obs_state(), 32'(S_MEMREAD));
    do_reset();

    issue(7'h00, 3'd0, 1'b0, 0, 0, 0, 0, 0);       // illegal opcode -> sticky trap
    repeat (150) rand_issue();

    // Second instance: no handshake, illegal opcodes fall back to FETCH.
    sel = 1'b1;
    hs  = 1'b0;
    trp = 1'b0;
    do_reset();
    issue(7'h00,   3'd0, 1'b0, 0, 0, 0, 0, 0);
    issue(OP_LOAD, 3'd2, 1'b0, 0, 0, 0, 3, 3);
    repeat (40) rand_issue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
